mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Shares the single AXI-style memory read channel between two cache refill engines: requester 0 is the i-cache, requester 1 is the d-cache.
- Arbitrates address requests round-robin and keeps one burst outstanding at a time.
- Returns each data beat only to the requester that owns the current burst.
- Sits between the cache refill FSMs and the memory/AXI bridge.

Parameters:
ADDR_WIDTH, 26, byte-address width of ARADDR
DATA_WIDTH, 32, width of RDATA
LEN_WIDTH, 8, width of ARLEN; value = number of beats, 0 treated as 1

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
s0_araddr  in  ADDR_WIDTH  requester 0 burst address
s0_arlen  in  LEN_WIDTH  requester 0 beat count
s0_arvalid  in  1  requester 0 address valid; held until s0_arready
s0_arready  out  1  requester 0 address accepted
s0_rdata  out  DATA_WIDTH  data to requester 0
s0_rvalid  out  1  beat valid to requester 0
s0_rready  in  1  requester 0 beat accept
s1_araddr, s1_arlen, s1_arvalid, s1_arready, s1_rdata, s1_rvalid, s1_rready  (same widths)  requester 1 equivalents
m_araddr  out  ADDR_WIDTH  memory burst address
m_arlen  out  LEN_WIDTH  memory beat count
m_arid  out  4  ID of the granted requester (4'd0 or 4'd1)
m_arvalid  out  1  memory address valid
m_arready  in  1  memory address accepted
m_rdata  in  DATA_WIDTH  memory read data
m_rvalid  in  1  memory beat valid
m_rready  out  1  beat accept to memory
busy  out  1  a burst is granted (state != IDLE)
grant  out  1  index of the current/last owner

Behaviour:
- FSM states IDLE, ADDR, DATA. Registers:
  - grant
  - last_grant (reset 1, so requester 0 wins the first tie)
  - r_addr, r_len
  - beat_cnt (LEN_WIDTH bits, reset 0)
- Reset: state=IDLE; m_arvalid=0; m_rready=0; all s*_arready=0; all s*_rvalid=0; busy=0; grant=0; beat_cnt=0.
- Reset mid-burst aborts the burst. No recovery is attempted; the memory side is reset together with the arbiter.
- IDLE:
  - If exactly one s*_arvalid is set, grant that requester.
  - If both are set, grant the requester != last_grant.
  - On a grant, capture that requester's araddr into r_addr and its arlen into r_len (0 becomes 1), then go to ADDR next cycle.
  - Arbitration adds one cycle of latency.
- ADDR:
  - m_arvalid=1; m_araddr=r_addr; m_arlen=r_len; m_arid=grant.
  - s[grant]_arready = m_arready, driven combinationally. The other requester's arready stays 0.
  - On m_arready: beat_cnt=0, go to DATA.
  - The losing requester keeps its arvalid asserted and is served after the current burst.
- DATA:
  - m_rready = s[grant]_rready.
  - s[grant]_rvalid = m_rvalid; the other requester's rvalid is 0.
  - m_rdata is driven to both s*_rdata; only rvalid qualifies it.
  - Each m_rvalid & m_rready beat increments beat_cnt.
  - On the beat where beat_cnt == r_len-1: set last_grant=grant and go to IDLE.
- Outside DATA: m_rready=0 and all s*_rvalid=0; stray memory beats are not consumed.
- Back-to-back bursts: IDLE can grant in the cycle after the last beat. Minimum gap between bursts is 1 idle cycle.
- No starvation: a requester that is pending while the other is granted wins the next arbitration.
- busy=1 in ADDR and DATA.
- grant holds its value through IDLE until the next grant.

Test Plan:
1. Reset, then s0_arvalid with araddr=0x0000100, arlen=4; memory gives ARREADY after 2 cycles and 4 beats 0xA0..0xA3 -> m_arid=0, s0_arready pulses once, s0 receives A0..A3 in order, s1_rvalid stays 0, FSM returns to IDLE after beat 4.
2. s0 and s1 both request in the same cycle after reset -> s0 is served first; s1 is granted in the cycle after s0's last beat with m_arid=1 and m_araddr=s1_araddr.
3. Both requesters assert arvalid continuously for 4 bursts -> grants alternate 0,1,0,1.
4. During a requester 1 burst, deassert s1_rready for 3 cycles while m_rvalid=1 -> m_rready=0 during the stall, no beat is lost or duplicated, and beat_cnt advances only on handshakes.
5. arlen=0 -> exactly one beat is transferred, then IDLE.
6. Assert rst_n=0 during DATA after beat 2 of 4 -> next cycle state=IDLE, all outputs 0; after release, a new s1 request is granted normally.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - two-requester round-robin arbiter for one AXI-style read channel
//
// Purpose:
//   Shares one memory read channel between the i-cache refill engine (requester 0)
//   and the d-cache refill engine (requester 1). Address requests are arbitrated
//   round-robin, only one burst is outstanding at a time, and each data beat is
//   routed only to the requester that owns the current burst.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   sN_araddr/arlen/arvalid/arready requester N address channel (N = 0, 1)
//   sN_rdata/rvalid/rready          requester N data channel
//   m_araddr/arlen/arid/arvalid/arready  memory address channel
//   m_rdata/rvalid/rready           memory data channel
//   busy                            a burst is granted (address or data phase)
//   grant                           index of the current / most recent owner
module mem_read_arbiter #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [LEN_WIDTH-1:0]  s0_arlen,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,

  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [LEN_WIDTH-1:0]  s1_arlen,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,

  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [LEN_WIDTH-1:0]  m_arlen,
  output logic [3:0]            m_arid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rvalid,
  output logic                  m_rready,

  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   r_addr_q, r_addr_d;
  logic [LEN_WIDTH-1:0]    r_len_q, r_len_d;
  logic [LEN_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;

  logic                    pick;
  logic [LEN_WIDTH-1:0]    len_sel;
  logic                    own_rready;

  // last_grant resets to 1 so that requester 0 wins the very first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      r_addr_q     <= '0;
      r_len_q      <= LEN_WIDTH'(1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      r_addr_q     <= r_addr_d;
      r_len_q      <= r_len_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Read data fans out to both requesters; only rvalid says whose beat it is.
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;

  assign m_araddr = r_addr_q;
  assign m_arlen  = r_len_q;
  assign m_arid   = {3'b000, grant_q};
  assign busy     = (state_q != ST_IDLE);
  assign grant    = grant_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    r_addr_d     = r_addr_q;
    r_len_d      = r_len_q;
    beat_cnt_d   = beat_cnt_q;

    pick         = 1'b0;
    len_sel      = '0;
    own_rready   = grant_q ? s1_rready : s0_rready;

    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    s0_arready   = 1'b0;
    s1_arready   = 1'b0;
    s0_rvalid    = 1'b0;
    s1_rvalid    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (s0_arvalid || s1_arvalid) begin
          // On a tie the requester that did not own the previous burst wins.
          pick     = (s0_arvalid && s1_arvalid) ? ~last_grant_q : s1_arvalid;
          len_sel  = pick ? s1_arlen : s0_arlen;
          grant_d  = pick;
          r_addr_d = pick ? s1_araddr : s0_araddr;
          r_len_d  = (len_sel == '0) ? LEN_WIDTH'(1) : len_sel;
          state_d  = ST_ADDR;
        end
      end

      ST_ADDR: begin
        m_arvalid = 1'b1;
        if (grant_q) s1_arready = m_arready;
        else         s0_arready = m_arready;
        if (m_arready) begin
          beat_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end

      ST_DATA: begin
        m_rready  = own_rready;
        s0_rvalid = !grant_q && m_rvalid;
        s1_rvalid =  grant_q && m_rvalid;
        if (m_rvalid && own_rready) begin
          beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          if (beat_cnt_q == r_len_q - LEN_WIDTH'(1)) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - self-checking bench for mem_read_arbiter
module tb_mem_read_arbiter;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] s0_araddr, s1_araddr, m_araddr;
  logic [LW-1:0] s0_arlen, s1_arlen, m_arlen;
  logic          s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [DW-1:0] s0_rdata, s1_rdata, m_rdata;
  logic          s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic [3:0]    m_arid;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic          busy, grant;

  mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .grant(grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester-side environment
  bit            req_pend[2];
  logic [AW-1:0] req_addr[2];
  logic [LW-1:0] req_len[2];
  bit            req_out[2];
  logic [AW-1:0] exp_addr[2];
  int            exp_len[2], rcvd[2], done[2], arready_pulses[2];
  int            rr_pct[2];
  bit            auto_req;
  int            req_pct;

  // Memory-side environment
  typedef struct { logic [AW-1:0] a; int n; } burst_t;
  burst_t        mem_q[$];
  int            mem_beat, mem_wait, mem_delay, ar_delay_cfg, rv_pct, stray_pct;
  bit            mem_rv;

  // Reference model: who owns the channel, which phase, beats still to come
  bit            md_busy, md_addr_ph;
  int            md_owner, md_last, md_len, md_rem;
  logic [AW-1:0] md_addr;
  int            grant_log[$];

  function automatic logic [DW-1:0] dfn(input logic [AW-1:0] a, input int k);
    return {a, k[5:0]};
  endfunction

  function automatic int pick_delay();
    return (ar_delay_cfg >= 0) ? ar_delay_cfg : int'($urandom_range(3));
  endfunction

  task automatic new_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] n);
    req_pend[i] = 1'b1;
    req_addr[i] = a;
    req_len[i]  = n;
  endtask

  // One clock: drive inputs, check at negedge, advance model and environment.
  task automatic cycle();
    burst_t b;
    bit     own_rr;
    s0_arvalid = req_pend[0]; s0_araddr = req_addr[0]; s0_arlen = req_len[0];
    s1_arvalid = req_pend[1]; s1_araddr = req_addr[1]; s1_arlen = req_len[1];
    s0_rready  = ($urandom_range(99) < rr_pct[0]);
    s1_rready  = ($urandom_range(99) < rr_pct[1]);
    m_arready  = m_arvalid && (mem_wait >= mem_delay);
    if (mem_q.size() > 0) begin
      if (!mem_rv) mem_rv = ($urandom_range(99) < rv_pct);
      m_rvalid = mem_rv;
      m_rdata  = dfn(mem_q[0].a, mem_beat);
    end else begin
      m_rvalid = ($urandom_range(99) < stray_pct);
      m_rdata  = $urandom;
    end

    @(negedge clk);
    own_rr = (md_owner == 1) ? s1_rready : s0_rready;
    chk("busy", 32'(busy), 32'(md_busy));
    chk("grant", 32'(grant), 32'(md_owner));
    chk("m_arvalid", 32'(m_arvalid), 32'(md_busy && md_addr_ph));
    if (md_busy && md_addr_ph) begin
      chk("m_arid", 32'(m_arid), 32'(md_owner));
      chk("m_araddr", 32'(m_araddr), 32'(md_addr));
      chk("m_arlen", 32'(m_arlen), 32'(md_len));
    end
    chk("s0_arready", 32'(s0_arready), 32'(md_busy && md_addr_ph && md_owner == 0 && m_arready));
    chk("s1_arready", 32'(s1_arready), 32'(md_busy && md_addr_ph && md_owner == 1 && m_arready));
    chk("m_rready", 32'(m_rready), 32'(md_busy && !md_addr_ph && own_rr));
    chk("s0_rvalid", 32'(s0_rvalid), 32'(md_busy && !md_addr_ph && md_owner == 0 && m_rvalid));
    chk("s1_rvalid", 32'(s1_rvalid), 32'(md_busy && !md_addr_ph && md_owner == 1 && m_rvalid));
    chk("s0_rdata", s0_rdata, m_rdata);
    chk("s1_rdata", s1_rdata, m_rdata);

    if (!rst_n) begin
      md_busy = 0; md_addr_ph = 0; md_owner = 0; md_last = 1;
      for (int i = 0; i < 2; i++) begin req_pend[i] = 0; req_out[i] = 0; end
      mem_q.delete(); mem_beat = 0; mem_rv = 0; mem_wait = 0; mem_delay = pick_delay();
      grant_log.delete();
    end else begin
      // model
      if (!md_busy) begin
        if (s0_arvalid || s1_arvalid) begin
          md_owner   = (s0_arvalid && s1_arvalid) ? 1 - md_last : (s1_arvalid ? 1 : 0);
          md_addr    = md_owner ? s1_araddr : s0_araddr;
          md_len     = int'(md_owner ? s1_arlen : s0_arlen);
          if (md_len == 0) md_len = 1;
          md_busy    = 1; md_addr_ph = 1;
        end
      end else if (md_addr_ph) begin
        if (m_arready) begin md_addr_ph = 0; md_rem = md_len; grant_log.push_back(md_owner); end
      end else if (m_rvalid && own_rr) begin
        md_rem--;
        if (md_rem == 0) begin md_busy = 0; md_last = md_owner; end
      end
      // requesters
      for (int i = 0; i < 2; i++) begin
        logic arv, arr, rv, rr;
        logic [DW-1:0] rd;
        arv = i ? s1_arvalid : s0_arvalid; arr = i ? s1_arready : s0_arready;
        rv  = i ? s1_rvalid : s0_rvalid;   rr  = i ? s1_rready : s0_rready;
        rd  = i ? s1_rdata : s0_rdata;
        if (arv && arr) begin
          arready_pulses[i]++; req_pend[i] = 0; req_out[i] = 1;
          exp_addr[i] = req_addr[i]; exp_len[i] = (req_len[i] == 0) ? 1 : int'(req_len[i]); rcvd[i] = 0;
        end
        if (rv && rr) begin
          chk("beat_owned", 32'(req_out[i]), 32'd1);
          chk("beat_data", rd, dfn(exp_addr[i], rcvd[i]));
          rcvd[i]++;
          if (rcvd[i] == exp_len[i]) begin req_out[i] = 0; done[i]++; end
        end
        if (auto_req && !req_pend[i] && !req_out[i] && $urandom_range(99) < req_pct)
          new_req(i, AW'($urandom), LW'($urandom_range(5)));
      end
      // memory
      if (m_arvalid && m_arready) begin
        b.a = m_araddr; b.n = (m_arlen == 0) ? 1 : int'(m_arlen);
        mem_q.push_back(b); mem_wait = 0; mem_delay = pick_delay();
      end else if (m_arvalid) mem_wait++;
      if (m_rvalid && m_rready && mem_q.size() > 0) begin
        mem_beat++; mem_rv = 0;
        if (mem_beat == mem_q[0].n) begin void'(mem_q.pop_front()); mem_beat = 0; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_until_done(input int i, input int n, input int budget);
    int k = 0;
    while (done[i] < n && k < budget) begin cycle(); k++; end
    chk("wait_done", 32'(done[i] >= n), 32'd1);
  endtask

  task automatic run_until_rcvd(input int i, input int n, input int budget);
    int k = 0;
    while (!(req_out[i] && rcvd[i] >= n) && k < budget) begin cycle(); k++; end
    chk("wait_rcvd", 32'(req_out[i] && rcvd[i] >= n), 32'd1);
  endtask

  task automatic run_until_grants(input int n, input int budget);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin cycle(); k++; end
    chk("wait_grants", 32'(grant_log.size() >= n), 32'd1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((req_pend[0] || req_pend[1] || req_out[0] || req_out[1] || md_busy) && k < budget) begin
      cycle(); k++;
    end
    chk("drain", 32'(md_busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
  endtask

  initial begin
    int d;
    rst_n = 1'b0;
    s0_arvalid = 0; s1_arvalid = 0; s0_araddr = '0; s1_araddr = '0; s0_arlen = '0; s1_arlen = '0;
    s0_rready = 0; s1_rready = 0; m_arready = 0; m_rvalid = 0; m_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      req_pend[i] = 0; req_out[i] = 0; req_addr[i] = '0; req_len[i] = '0; exp_addr[i] = '0;
      exp_len[i] = 0; rcvd[i] = 0; done[i] = 0; arready_pulses[i] = 0; rr_pct[i] = 100;
    end
    auto_req = 0; req_pct = 0; rv_pct = 100; stray_pct = 0; ar_delay_cfg = 2;
    mem_beat = 0; mem_wait = 0; mem_delay = 2; mem_rv = 0;
    md_busy = 0; md_addr_ph = 0; md_owner = 0; md_last = 1; md_len = 1; md_rem = 0; md_addr = '0;
    @(posedge clk); #1;
    do_reset();

    // reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_m_rready", 32'(m_rready), 32'd0);

    // single s0 burst of 4, ARREADY after 2 cycles
    new_req(0, 26'h0000100, 8'd4);
    run_until_done(0, 1, 60);
    chk("t1_arready_pulses", 32'(arready_pulses[0]), 32'd1);
    chk("t1_rcvd", 32'(rcvd[0]), 32'd4);
    chk("t1_arid", 32'(grant_log[0]), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_s1_none", 32'(done[1]), 32'd0);

    // simultaneous requests after reset: s0 first, then s1
    do_reset();
    ar_delay_cfg = 0;
    new_req(0, 26'h0000200, 8'd2);
    new_req(1, 26'h0002000, 8'd3);
    run_until_done(1, 1, 80);
    chk("t2_first", 32'(grant_log[0]), 32'd0);
    chk("t2_second", 32'(grant_log[1]), 32'd1);
    chk("t2_s0_done", 32'(done[0]), 32'd2);

    // continuous requests alternate 0,1,0,1
    grant_log.delete();
    auto_req = 1; req_pct = 100; ar_delay_cfg = -1; rv_pct = 70;
    run_until_grants(4, 400);
    for (int g = 0; g < 4; g++) chk("t3_alternate", 32'(grant_log[g]), 32'(g % 2));
    auto_req = 0;
    drain(400);

    // s1 rready stall for 3 cycles mid-burst
    rv_pct = 100; ar_delay_cfg = 0; rr_pct[0] = 100; rr_pct[1] = 100;
    d = done[1];
    new_req(1, 26'h0003000, 8'd4);
    run_until_rcvd(1, 1, 40);
    rr_pct[1] = 0;
    repeat (3) cycle();
    chk("t4_stall_rcvd", 32'(rcvd[1]), 32'd1);
    rr_pct[1] = 100;
    run_until_done(1, d + 1, 40);
    chk("t4_total", 32'(rcvd[1]), 32'd4);

    // arlen = 0 is a single beat
    d = done[0];
    new_req(0, 26'h0004000, 8'd0);
    run_until_done(0, d + 1, 40);
    chk("t5_rcvd", 32'(rcvd[0]), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);

    // reset during DATA after beat 2 of 4
    new_req(1, 26'h0005000, 8'd4);
    run_until_rcvd(1, 2, 40);
    do_reset();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_m_rready", 32'(m_rready), 32'd0);
    chk("t6_s1_rvalid", 32'(s1_rvalid), 32'd0);
    chk("t6_m_arvalid", 32'(m_arvalid), 32'd0);
    d = done[1];
    new_req(1, 26'h0006000, 8'd2);
    run_until_done(1, d + 1, 40);
    chk("t6_regrant", 32'(grant_log[0]), 32'd1);

    // randomized traffic with stray beats and back-pressure
    auto_req = 1; req_pct = 30; rv_pct = 60; stray_pct = 20; ar_delay_cfg = -1;
    for (int blk = 0; blk < 10; blk++) begin
      rr_pct[0] = int'($urandom_range(100, 40));
      rr_pct[1] = int'($urandom_range(100, 40));
      repeat (200) cycle();
    end
    chk("rand_s0_progress", 32'(done[0] > 10), 32'd1);
    chk("rand_s1_progress", 32'(done[1] > 10), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
